// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with mid-bit sampling, stop-bit check and a
// single-entry holding register with valid/read handshake and sticky overrun.
module uart_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      clock_divider,
    input  logic             rx,
    input  logic             read_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic             valid_q, valid_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q, overrun_d;
    logic             rxMeta_q, rxs_q;
    logic [15:0]      periodM1, halfM1;

    // The counter holds "cycles remaining minus one", so P = 65536 still fits in 16 bits.
    assign periodM1 = (clock_divider == 16'd0) ? 16'd1 : clock_divider;
    assign halfM1   = (periodM1 - 16'd1) >> 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q   <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            dataOut_q  <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rxMeta_q   <= rx;
            rxs_q      <= rxMeta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            dataOut_q  <= dataOut_d;
            valid_q    <= valid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        dataOut_d  = dataOut_q;
        valid_d    = valid_q;
        frameErr_d = 1'b0;
        overrun_d  = overrun_q;

        // A read is applied first so a same-cycle accept can re-set valid over it.
        if (read_en && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = halfM1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d    = periodM1;
                        bitCnt_d = '0;
                        state_d  = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d  = {rxs_q, shift_q[WIDTH-1:1]};
                    cnt_d    = periodM1;
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == BW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rxs_q) begin
                        dataOut_d = shift_q;
                        valid_d   = 1'b1;
                        if (valid_q && !read_en) begin
                            overrun_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out    = dataOut_q;
    assign data_valid  = valid_q;
    assign frame_error = frameErr_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-bangs frames on rx and checks accept timing,
// data, framing error, false start, overrun, simultaneous read and reset.
module tb_uart_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] clock_divider;
    logic        rx;
    logic        read_en;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_error;
    logic        overrun;
    logic        busy;

    int compared = 0;
    int mismatched = 0;
    int cycleCount = 0;
    int acceptCount = 0;
    int lastAcceptCycle = -1;
    int ferrCycles = 0;
    int lastStart = 0;
    int baseAccept, baseFerr, startCycle;
    logic       prevValid = 1'b0;
    logic [7:0] prevData = 8'h00;

    uart_rx #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .clock_divider(clock_divider),
        .rx           (rx),
        .read_en      (read_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // An accept is a new word appearing in the holding register with valid high.
    always begin
        @(posedge clock);
        #1;
        if (data_valid && (!prevValid || data_out != prevData)) begin
            acceptCount++;
            lastAcceptCycle = cycleCount;
        end
        if (frame_error) ferrCycles++;
        prevValid = data_valid;
        prevData  = data_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one frame starting at a falling clock edge; readAt pulses read_en at that clock offset.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int period,
                                 input int readAt, input int numClocks);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        lastStart = cycleCount;
        for (int k = 0; k < numClocks; k++) begin
            rx      = bits[k / period];
            read_en = (k == readAt);
            @(negedge clock);
        end
        read_en = 1'b0;
    endtask

    initial begin
        rx = 1'b1;
        read_en = 1'b0;
        reset = 1'b1;
        clock_divider = 16'd1;
        repeat (3) @(negedge clock);
        checkOutput("reset data_out", data_out, 0);
        checkOutput("reset data_valid", data_valid, 0);
        checkOutput("reset frame_error", frame_error, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // P = 2, H = 1: stop sampled at t0+19, t0 three edges after the line drop.
        baseAccept = acceptCount;
        baseFerr = ferrCycles;
        applyStimulus(8'hAA, 1'b1, 2, -1, 20);
        rx = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("p2 accept count", acceptCount - baseAccept, 1);
        checkOutput("p2 data_out", data_out, 8'hAA);
        checkOutput("p2 data_valid", data_valid, 1);
        checkOutput("p2 frame_error", ferrCycles - baseFerr, 0);
        checkOutput("p2 overrun", overrun, 0);
        checkOutput("p2 latency", lastAcceptCycle - lastStart, 22);
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        checkOutput("p2 read clears valid", data_valid, 0);

        // P = 16, back-to-back frames: valid edge at 3 + 8 + 9*16 = 155 clocks after drop.
        clock_divider = 16'd15;
        repeat (4) @(negedge clock);
        baseAccept = acceptCount;
        applyStimulus(8'h5A, 1'b1, 16, -1, 160);
        checkOutput("b2b lat 0x5A", lastAcceptCycle - lastStart, 155);
        checkOutput("b2b data 0x5A", data_out, 8'h5A);
        applyStimulus(8'hFF, 1'b1, 16, -1, 160);
        rx = 1'b1;
        checkOutput("b2b lat 0xFF", lastAcceptCycle - lastStart, 155);
        checkOutput("b2b data 0xFF", data_out, 8'hFF);
        checkOutput("b2b accept count", acceptCount - baseAccept, 2);
        checkOutput("b2b overrun", overrun, 1);
        repeat (4) @(negedge clock);
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        checkOutput("b2b read valid", data_valid, 0);
        checkOutput("b2b read overrun", overrun, 0);

        // False start: start sample at t0+8 sees high, IDLE after the 11th edge.
        repeat (4) @(negedge clock);
        baseAccept = acceptCount;
        startCycle = cycleCount;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("false start busy +10", busy, 1);
        @(negedge clock);
        checkOutput("false start busy +11", busy, 0);
        checkOutput("false start elapsed", cycleCount - startCycle, 11);
        repeat (20) @(negedge clock);
        checkOutput("false start valid", data_valid, 0);
        checkOutput("false start accepts", acceptCount - baseAccept, 0);

        // Framing error with a held break afterwards.
        baseAccept = acceptCount;
        baseFerr = ferrCycles;
        applyStimulus(8'h3C, 1'b0, 16, -1, 160);
        rx = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("ferr busy in break", busy, 1);
        checkOutput("ferr pulse cycles", ferrCycles - baseFerr, 1);
        checkOutput("ferr valid", data_valid, 0);
        rx = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("ferr busy released", busy, 0);
        repeat (200) @(negedge clock);
        checkOutput("ferr no spurious", acceptCount - baseAccept, 0);
        checkOutput("ferr valid after", data_valid, 0);
        checkOutput("ferr data_out kept", data_out, 8'hFF);

        // Overrun without reads.
        applyStimulus(8'h11, 1'b1, 16, -1, 160);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        applyStimulus(8'h22, 1'b1, 16, -1, 160);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("ovr overrun", overrun, 1);
        checkOutput("ovr data_out", data_out, 8'h22);
        checkOutput("ovr valid", data_valid, 1);
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        checkOutput("ovr read valid", data_valid, 0);
        checkOutput("ovr read overrun", overrun, 0);

        // Read asserted in the accept cycle of the second word (offset 154 sampled at edge 155).
        baseAccept = acceptCount;
        applyStimulus(8'h11, 1'b1, 16, -1, 160);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        applyStimulus(8'h22, 1'b1, 16, 154, 160);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("simul overrun", overrun, 0);
        checkOutput("simul valid", data_valid, 1);
        checkOutput("simul data_out", data_out, 8'h22);
        checkOutput("simul accepts", acceptCount - baseAccept, 2);
        checkOutput("simul lat", lastAcceptCycle - lastStart, 155);
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;

        // Reset during data bit 3, then a clean frame.
        repeat (3) @(negedge clock);
        applyStimulus(8'h96, 1'b1, 16, -1, 70);
        checkOutput("midreset busy before", busy, 1);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midreset data_out", data_out, 0);
        checkOutput("midreset valid", data_valid, 0);
        checkOutput("midreset frame_error", frame_error, 0);
        checkOutput("midreset overrun", overrun, 0);
        checkOutput("midreset busy", busy, 0);
        repeat (100) @(negedge clock);
        baseFerr = ferrCycles;
        applyStimulus(8'h96, 1'b1, 16, -1, 160);
        rx = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("post reset data", data_out, 8'h96);
        checkOutput("post reset valid", data_valid, 1);
        checkOutput("post reset lat", lastAcceptCycle - lastStart, 155);
        checkOutput("post reset ferr", ferrCycles - baseFerr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
